// File: rtl/uart_sim_pkg.sv
// Shared definitions for the simulation UART transmitter and receiver:
// frame FSM encoding and the baud divider computation.
package uart_sim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Clock cycles per bit, truncating.
  function automatic int calc_baud_div(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sim_fifo.sv
// Small synchronous FIFO with a first-word-fall-through read port.
// Full/empty come from an occupancy count one bit wider than the pointers.
module uart_sim_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_sim_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are exactly log2(DEPTH) bits, so the increment wraps modulo depth.
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; the count alone decides which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_sim_transmitter.sv
// Buffered 8N1 UART transmitter used to feed a processor's receive pin in simulation.
// Bytes queue in a FIFO; frames go out back to back while the FIFO holds data.
module uart_sim_transmitter
  import uart_sim_pkg::*;
#(
  parameter int CLOCK_FREQ = 100000000,
  parameter int BAUD_RATE  = 19200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       txd_o,
  output logic       busy_o
);

  localparam int BAUD_DIV = calc_baud_div(CLOCK_FREQ, BAUD_RATE);
  localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(BAUD_DIV - 1);

  if (BAUD_DIV < 2) begin : g_baud_check
    $error("uart_sim_transmitter: CLOCK_FREQ/BAUD_RATE must be at least 2");
  end

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             bit_end;
  logic             pop;
  logic [7:0]       fifo_data;
  logic             fifo_full, fifo_empty;

  uart_sim_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (valid_i),
    .data_i  (data_i),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign ready_o = !fifo_full;
  assign busy_o  = (state_q != ST_IDLE) || !fifo_empty;
  assign txd_o   = txd_q;
  assign bit_end = (baud_cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    txd_d      = txd_q;
    pop        = 1'b0;

    if (state_q != ST_IDLE) baud_cnt_d = bit_end ? BAUD_RELOAD : baud_cnt_q - 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = fifo_data;
          state_d    = ST_START;
          txd_d      = 1'b0;
          baud_cnt_d = BAUD_RELOAD;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
          txd_d     = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            txd_d   = 1'b1;
          end else begin
            // txd_d takes the next bit directly so the line changes only at the register.
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_data;
            state_d = ST_START;
            txd_d   = 1'b0;
          end else begin
            state_d    = ST_IDLE;
            txd_d      = 1'b1;
            baud_cnt_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_sim_transmitter.sv
// Directed bench for uart_sim_transmitter at a reduced bit period of 8 clocks;
// every txd_o cycle of every frame is compared with the hand-derived 8N1 waveform.
module tb_uart_sim_transmitter;

  localparam int CLOCK_FREQ = 80;
  localparam int BAUD_RATE  = 10;
  localparam int BD         = 8;   // 80 / 10

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic       txd_o;
  logic       busy_o;

  int    n_checks = 0;
  int    n_fail   = 0;
  string rx_str;

  uart_sim_transmitter #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .txd_o   (txd_o),
    .busy_o  (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Push each character of s, holding valid_i high and advancing only on accepted edges.
  task automatic push_seq(input string s);
    int  i;
    int  guard;
    logic r;
    i = 0;
    guard = 0;
    valid_i = 1'b1;
    data_i  = s[0];
    while (i < s.len() && guard < 5000) begin
      r = ready_o;
      tick();
      guard++;
      if (r) i++;
      if (i < s.len()) data_i = s[i];
    end
    valid_i = 1'b0;
    check($sformatf("push_seq_%s_accepted", s), i, s.len());
  endtask

  // Called at the first sample of a start bit; returns at the first sample after the stop bit.
  task automatic check_frame(input logic [7:0] b, input bit end_push, input logic [7:0] pb);
    logic [9:0] bits;
    logic [7:0] rx;
    int         good;
    bits = {1'b1, b, 1'b0};
    rx   = '0;
    for (int k = 0; k < 10; k++) begin
      good = 0;
      for (int c = 0; c < BD; c++) begin
        if (txd_o === bits[k]) good++;
        if (c == BD / 2 && k >= 1 && k <= 8) rx[k-1] = txd_o;
        if (end_push && k == 9 && c == BD - 1) begin
          valid_i = 1'b1;
          data_i  = pb;
        end
        tick();
      end
      check($sformatf("frame_%02h_bit%0d_cycles", b, k), good, BD);
    end
    if (end_push) valid_i = 1'b0;
    check($sformatf("frame_%02h_rx_byte", b), rx, b);
    rx_str = $sformatf("%s%c", rx_str, rx);
  endtask

  task automatic check_frames(input string s);
    for (int i = 0; i < s.len(); i++) check_frame(s[i], 1'b0, 8'h00);
  endtask

  initial begin
    int hi_cycles;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    data_i  = 8'h00;
    tick();
    tick();
    check("reset_txd", txd_o, 1'b1);
    check("reset_busy", busy_o, 1'b0);
    check("reset_ready", ready_o, 1'b1);
    rst_i = 1'b0;
    tick();
    check("idle_txd", txd_o, 1'b1);

    // Single byte 0x4E: push at edge N, start bit after N+1, idle after one frame.
    valid_i = 1'b1;
    data_i  = 8'h4E;
    tick();
    valid_i = 1'b0;
    check("4e_busy_after_push", busy_o, 1'b1);
    check("4e_txd_high_at_push", txd_o, 1'b1);
    tick();
    check("4e_txd_low_next_edge", txd_o, 1'b0);
    check("4e_fifo_popped", dut.u_fifo.count_q, 0);
    check_frame(8'h4E, 1'b0, 8'h00);
    check("4e_busy_done", busy_o, 1'b0);
    check("4e_txd_idle", txd_o, 1'b1);

    // 0x00 then 0xFF back to back.
    valid_i = 1'b1;
    data_i  = 8'h00;
    tick();
    data_i  = 8'hFF;
    tick();
    valid_i = 1'b0;
    check_frame(8'h00, 1'b0, 8'h00);
    check_frame(8'hFF, 1'b0, 8'h00);
    check("00ff_busy_done", busy_o, 1'b0);

    // Burst "NEORV32" with valid_i held high; FIFO fills to 4 after five accepted bytes.
    rx_str = "";
    fork
      push_seq("NEORV32");
      begin
        tick();
        tick();
        check_frames("NEORV32");
      end
      begin
        repeat (5) @(posedge clk_i);
        #1;
        check("burst_ready_low_when_full", ready_o, 1'b0);
        check("burst_count_full", dut.u_fifo.count_q, 4);
      end
    join
    $display("loopback received: %s", rx_str);
    check("burst_busy_done", busy_o, 1'b0);

    // 0xAA pulsed while full is dropped and never transmitted.
    fork
      begin
        push_seq("abcde");
        check("drop_count_before", dut.u_fifo.count_q, 4);
        valid_i = 1'b1;
        data_i  = 8'hAA;
        tick();
        valid_i = 1'b0;
        check("drop_count_after", dut.u_fifo.count_q, 4);
        check("drop_ready_low", ready_o, 1'b0);
      end
      begin
        tick();
        tick();
        check_frames("abcde");
      end
    join
    check("drop_busy_done", busy_o, 1'b0);
    check("drop_txd_idle", txd_o, 1'b1);

    // Push on the same edge as the STOP-end pop with three bytes buffered.
    fork
      push_seq("ABCD");
      begin
        tick();
        tick();
        check_frame(8'h41, 1'b1, 8'h45);
        check("order_count_kept", dut.u_fifo.count_q, 3);
        check_frames("BCDE");
      end
    join
    check("order_busy_done", busy_o, 1'b0);

    // Reset in the middle of data bit 3 of 0x72 (bit 3 is 0) with two bytes buffered.
    fork
      push_seq("rst");
      begin
        tick();
        tick();
        repeat (4 * BD + BD / 2) tick();
      end
    join
    check("rst_pre_txd_low", txd_o, 1'b0);
    check("rst_pre_count", dut.u_fifo.count_q, 2);
    #2;
    rst_i = 1'b1;
    #1;
    check("rst_async_txd", txd_o, 1'b1);
    check("rst_async_busy", busy_o, 1'b0);
    check("rst_async_ready", ready_o, 1'b1);
    check("rst_async_count", dut.u_fifo.count_q, 0);
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    check("rst_release_ready", ready_o, 1'b1);
    check("rst_release_busy", busy_o, 1'b0);
    hi_cycles = 0;
    for (int c = 0; c < 11 * 10 * BD; c++) begin
      if (txd_o === 1'b1) hi_cycles++;
      tick();
    end
    check("rst_txd_high_11_frames", hi_cycles, 11 * 10 * BD);
    check("rst_busy_stays_low", busy_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
